mul_share_sched: RTL and testbench

//   Shares one sequential repeated-addition multiplier among NREQ requesters.
//   A round-robin arbiter grants one requester at a time and latches its operands.
//   An FSM then adds a into an accumulator b times and returns the product with a
//   per-requester done pulse. Sits between the operand producers and the product consumers.

---
 rtl/mul_share_sched.sv | 174 +++++++++++++++++
 tb/tb_mul_share_sched.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/mul_share_sched.sv
// rtl/mul_share_sched.sv - round-robin shared repeated-addition multiplier
//
// Purpose:
//   One sequential multiplier shared by NREQ requesters. A round-robin arbiter
//   picks one requester in IDLE and latches its operands. The FSM then adds a
//   into an accumulator b times and returns the product with a one-hot done
//   pulse addressed to that requester.
//
// Ports:
//   clk    in   1           clock, rising edge
//   rst    in   1           synchronous active-high reset
//   req    in   NREQ        request vector
//   a_in   in   NREQ*WIDTH  operand a, slice i = a_in[i*WIDTH +: WIDTH]
//   b_in   in   NREQ*WIDTH  operand b (repeat count), same slicing
//   grant  out  NREQ        one-hot, high from latch cycle through DONE cycle
//   done   out  NREQ        one-hot 1-cycle pulse, sum valid in that cycle
//   sum    out  2*WIDTH     last completed product, held until next DONE
//   busy   out  1           high in every state except IDLE

module mul_share_sched #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] a_in,
  input  logic [NREQ*WIDTH-1:0] b_in,
  output logic [NREQ-1:0]       grant,
  output logic [NREQ-1:0]       done,
  output logic [2*WIDTH-1:0]    sum,
  output logic                  busy
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ADD,
    S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [WIDTH-1:0]    a_q, a_d;
  logic [WIDTH-1:0]    b_q, b_d;
  logic [2*WIDTH-1:0]  acc_q, acc_d;
  logic [WIDTH-1:0]    cnt_q, cnt_d;
  logic [IW-1:0]       win_q, win_d;
  logic [IW-1:0]       last_q, last_d;
  logic [NREQ-1:0]     grant_d;
  logic [NREQ-1:0]     done_d;
  logic [2*WIDTH-1:0]  sum_d;
  logic                busy_d;

  // Round-robin search: first set req bit starting at last_q+1, wrapping.
  logic [IW-1:0]       win;
  logic                any_req;
  logic [WIDTH-1:0]    a_sel;
  logic [WIDTH-1:0]    b_sel;

  always_comb begin
    int idx;
    logic [IW-1:0] idx_w;
    win     = '0;
    any_req = 1'b0;
    idx     = 0;
    idx_w   = '0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = int'(last_q) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      idx_w = IW'(idx);
      if (!any_req && req[idx_w]) begin
        any_req = 1'b1;
        win     = idx_w;
      end
    end
  end

  // Operand mux with constant slice bounds.
  always_comb begin
    a_sel = '0;
    b_sel = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (IW'(i) == win) begin
        a_sel = a_in[i*WIDTH +: WIDTH];
        b_sel = b_in[i*WIDTH +: WIDTH];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    win_d   = win_q;
    last_d  = last_q;
    grant_d = grant;
    done_d  = done;
    sum_d   = sum;
    busy_d  = busy;
    case (state_q)
      S_IDLE: begin
        if (any_req) begin
          a_d          = a_sel;
          b_d          = b_sel;
          acc_d        = '0;
          cnt_d        = '0;
          win_d        = win;
          grant_d      = '0;
          grant_d[win] = 1'b1;
          busy_d       = 1'b1;
          state_d      = S_ADD;
        end
      end
      S_ADD: begin
        // b_q+1 cycles: b_q additions, then one cycle to publish the result.
        if (cnt_q == b_q) begin
          sum_d          = acc_q;
          done_d         = '0;
          done_d[win_q]  = 1'b1;
          state_d        = S_DONE;
        end else begin
          acc_d = acc_q + {{WIDTH{1'b0}}, a_q};
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DONE: begin
        last_d  = win_q;
        grant_d = '0;
        done_d  = '0;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        grant_d = '0;
        done_d  = '0;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      win_q   <= '0;
      // Pointing at the last index makes requester 0 the first candidate.
      last_q  <= IW'(NREQ - 1);
      grant   <= '0;
      done    <= '0;
      sum     <= '0;
      busy    <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      win_q   <= win_d;
      last_q  <= last_d;
      grant   <= grant_d;
      done    <= done_d;
      sum     <= sum_d;
      busy    <= busy_d;
    end
  end

endmodule

// File: tb/tb_mul_share_sched.sv
// tb/tb_mul_share_sched.sv - scoreboard bench for mul_share_sched

module tb_mul_share_sched;

  logic        clk;
  logic        rst;
  logic [3:0]  req;
  logic [31:0] a_in;
  logic [31:0] b_in;
  logic [3:0]  grant;
  logic [3:0]  done;
  logic [15:0] sum;
  logic        busy;

  int n_total = 0;
  int n_pass  = 0;

  typedef struct {
    int idx;
    int prod;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  mul_share_sched #(.NREQ(4), .WIDTH(8)) dut (
    .clk   (clk),
    .rst   (rst),
    .req   (req),
    .a_in  (a_in),
    .b_in  (b_in),
    .grant (grant),
    .done  (done),
    .sum   (sum),
    .busy  (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int i, input int a, input int b);
    a_in[i*8 +: 8] = 8'(a);
    b_in[i*8 +: 8] = 8'(b);
  endtask

  task automatic push(input int i, input int p);
    exp_t e;
    e.idx  = i;
    e.prod = p;
    exp_q.push_back(e);
  endtask

  // Single requester, req held for the decision cycle only; p is hand-computed.
  task automatic run_one(input int i, input int a, input int b, input int p);
    set_op(i, a, b);
    req = 4'(1 << i);
    push(i, p);
    for (int c = 1; c <= b + 3; c++) begin
      tick();
      if (c == 1) req = 4'b0;
      @(negedge clk);
      if (c == 1) chk("grant_first", 32'(grant), 32'(1 << i));
      if (c == b + 1) chk("done_not_early", 32'(done), 32'd0);
      if (c == b + 2) begin
        chk("done_cycle", 32'(done), 32'(1 << i));
        chk("sum_at_done", 32'(sum), 32'(p));
        chk("grant_at_done", 32'(grant), 32'(1 << i));
      end
      if (c == b + 3) begin
        chk("busy_after", 32'(busy), 32'd0);
        chk("grant_after", 32'(grant), 32'd0);
      end
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a done pulse.
  always @(negedge clk) begin
    if (!rst) begin
      chk("onehot0", {30'b0, $onehot0(grant), $onehot0(done)}, 32'd3);
      if (done != 4'b0) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_done", 32'(done), 32'd0);
        end else begin
          mon_e = exp_q.pop_front();
          chk("sb_done_idx", 32'(done), 32'(1 << mon_e.idx));
          chk("sb_sum", 32'(sum), 32'(mon_e.prod));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [3:0] order [5];

  initial begin
    rst  = 1'b1;
    req  = 4'b0;
    a_in = 32'b0;
    b_in = 32'b0;

    // 1: reset values, then idle with req=0
    tick();
    tick();
    @(negedge clk);
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_sum", 32'(sum), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    tick();
    rst = 1'b0;
    tick();
    tick();
    @(negedge clk);
    chk("idle_grant", 32'(grant), 32'd0);
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_sum", 32'(sum), 32'd0);

    // 2: 5*3
    tick();
    run_one(0, 5, 3, 15);

    // 3: b=0 and the largest product
    tick();
    run_one(1, 200, 0, 0);
    tick();
    run_one(1, 255, 255, 65025);

    // 4: all four requesting, fresh priority from reset
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    set_op(0, 3, 1);
    set_op(1, 4, 1);
    set_op(2, 5, 1);
    set_op(3, 6, 1);
    order[0] = 4'b0001;
    order[1] = 4'b0010;
    order[2] = 4'b0100;
    order[3] = 4'b1000;
    order[4] = 4'b0001;
    push(0, 3);
    push(1, 4);
    push(2, 5);
    push(3, 6);
    push(0, 3);
    req = 4'b1111;
    for (int c = 1; c <= 22; c++) begin
      tick();
      if (c == 17) req = 4'b0;
      @(negedge clk);
      if ((c % 4) == 1) chk("rr_grant", 32'(grant), 32'(order[c / 4]));
    end

    // 5: operand/req changes during the operation are ignored
    tick();
    set_op(0, 7, 10);
    req = 4'b0001;
    push(0, 70);
    for (int c = 1; c <= 13; c++) begin
      tick();
      if (c == 3) begin
        set_op(0, 99, 2);
        req = 4'b0;
      end
      @(negedge clk);
      if (c == 11) chk("t5_done_not_early", 32'(done), 32'd0);
      if (c == 12) begin
        chk("t5_done", 32'(done), 32'd1);
        chk("t5_sum", 32'(sum), 32'd70);
      end
    end

    // 6: reset mid-operation abandons it
    tick();
    set_op(0, 9, 20);
    req = 4'b0001;
    for (int c = 1; c <= 9; c++) begin
      tick();
      if (c == 1) req = 4'b0;
      if (c == 8) rst = 1'b1;
      if (c == 9) rst = 1'b0;
    end
    @(negedge clk);
    chk("t6_grant", 32'(grant), 32'd0);
    chk("t6_done", 32'(done), 32'd0);
    chk("t6_sum", 32'(sum), 32'd0);
    chk("t6_busy", 32'(busy), 32'd0);
    for (int c = 0; c < 25; c++) tick();
    @(negedge clk);
    chk("t6_still_idle", 32'(busy), 32'd0);

    // requester 0 wins first after reset even though it won last before it
    tick();
    set_op(0, 2, 3);
    set_op(2, 11, 2);
    push(0, 6);
    push(2, 22);
    req = 4'b0101;
    for (int c = 1; c <= 13; c++) begin
      tick();
      if (c == 1) req = 4'b0100;
      if (c == 7) req = 4'b0;
      @(negedge clk);
      if (c == 1) chk("t6_first_grant", 32'(grant), 32'd1);
      if (c == 7) chk("t6_second_grant", 32'(grant), 32'd4);
      if (c == 10) chk("t6_second_done", 32'(done), 32'd4);
    end

    tick();
    tick();
    @(negedge clk);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
